// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers for the Execute stage.
// Results are computed from latched operands and committed atomically on the last busy cycle.
//
// state | meaning
// IDLE  | waiting for a request; MTHI/MTLO are applied here in one edge
// RUN   | multi-cycle op in flight, counter counts down to the commit edge
module mdu_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  // Even ops in 0..7 are the signed variants.
  logic               signed_op;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc, mac;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, b_div, uq, ur, quo, rem;

  always_comb begin
    signed_op = ~op_q[0];
    a_ext = signed_op ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext = signed_op ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    // Low 2*WIDTH bits of the extended product are exact for both signednesses.
    prod  = a_ext * b_ext;
    acc   = {hi_q, lo_q};
    mac   = op_q[1] ? (acc - prod) : (acc + prod);

    // Sign-magnitude division; MIN/-1 falls out as MIN with zero remainder.
    a_neg = signed_op & a_q[WIDTH-1];
    b_neg = signed_op & b_q[WIDTH-1];
    a_mag = a_neg ? (-a_q) : a_q;
    b_mag = b_neg ? (-b_q) : b_q;
    b_div = (b_mag == '0) ? WIDTH'(1) : b_mag;
    uq    = a_mag / b_div;
    ur    = a_mag % b_div;
    quo   = (a_neg ^ b_neg) ? (-uq) : uq;
    rem   = a_neg ? (-ur) : ur;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          if (op <= 4'd7) begin
            op_d    = op;
            a_d     = a;
            b_d     = b;
            cnt_d   = (op == 4'd2 || op == 4'd3) ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            state_d = RUN;
          end else if (op == 4'd8) begin
            hi_d = a;
          end else if (op == 4'd9) begin
            lo_d = a;
          end
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          case (op_q)
            4'd0, 4'd1: {hi_d, lo_d} = prod;
            4'd2, 4'd3: if (b_q != '0) {hi_d, lo_d} = {rem, quo};
            4'd4, 4'd5, 4'd6, 4'd7: {hi_d, lo_d} = mac;
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
